dmem_responder: RTL and testbench

Data-memory responder for the RV32 core's load/store port. It accepts one request at a time over a valid/ready handshake and stalls for a fixed number of wait states. It then performs a byte, half or word access on internal word-organised storage and returns the result over a second valid/ready handshake. It replaces the zero-latency data memory so the core and its pipelined successor can be exercised against realistic multi-cycle memory.

---
 rtl/dmem_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory for the RV32 load/store port.
// A request is accepted over a valid/ready handshake and then held for
// WAIT_CYCLES wait states. A byte, half or word access is then made on
// word-organised storage. The result is returned over a second handshake.
// Optional build macro: DMEM_MISALIGN_ERR_EN (fault misaligned half/word).
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    // First illegal byte address, one bit wider so the compare cannot wrap.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [2:0]         funct3_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        rdata_reg;
    logic               err_reg;

    logic [31:0]        mem_reg [DEPTH_WORDS];

    logic               latch_en;
    logic               access_en;
    logic               commit_en;

    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        rd_word;
    logic               f3_ok;
    logic               range_err;
    logic               align_err;
    logic               acc_err;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_data;
    logic [3:0]         byte_en;
    logic [31:0]        st_data;
    logic [31:0]        merged_word;

    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        latch_en   = 1'b0;
        access_en  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                cnt_next  = '0;
                if (req_valid) begin
                    latch_en   = 1'b1;
                    state_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_ACCESS;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_ACCESS: begin
                access_en  = 1'b1;
                state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Capture the request on the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            funct3_reg <= '0;
            wdata_reg  <= '0;
        end else if (latch_en) begin
            we_reg     <= req_we;
            addr_reg   <= req_addr;
            funct3_reg <= req_funct3;
            wdata_reg  <= req_wdata;
        end
    end

    assign word_idx = addr_reg[IDX_W+1:2];
    assign rd_word  = mem_reg[word_idx];

    // Decode the latched request: legality, load extraction, store lanes.
    always_comb begin
        f3_ok     = 1'b0;
        load_data = '0;
        byte_en   = '0;
        st_data   = '0;
        byte_sel  = '0;

        case (funct3_reg)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !we_reg;
            default:                f3_ok = 1'b0;
        endcase

        range_err = ({1'b0, addr_reg} >= ADDR_LIMIT);

`ifdef DMEM_MISALIGN_ERR_EN
        align_err = ((funct3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                    ((funct3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
`else
        // Low address bits below the access size are simply dropped.
        align_err = 1'b0;
`endif

        acc_err = !f3_ok || range_err || align_err;

        case (addr_reg[1:0])
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];

        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            3'b010:  load_data = rd_word;
            default: load_data = '0;
        endcase

        // Store data is replicated across lanes; byte_en picks the lanes.
        case (funct3_reg[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr_reg[1:0];
                st_data = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_reg[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                st_data = wdata_reg;
            end
            default: begin
                byte_en = 4'b0000;
                st_data = '0;
            end
        endcase
    end

    assign commit_en = access_en && we_reg && !acc_err;

    // Merge store bytes into the existing word lane by lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = byte_en[gi] ? st_data[8*gi +: 8]
                                                        : rd_word[8*gi +: 8];
        end
    endgenerate

    // Response registers, loaded once in ACCESS and held through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (access_en) begin
            err_reg   <= acc_err;
            rdata_reg <= (we_reg || acc_err) ? 32'd0 : load_data;
        end
    end

    // Storage: cleared by reset, one word written on a legal store commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (commit_en) begin
            mem_reg[word_idx] <= merged_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder (default parameters).
// Latency is counted with the accepting edge as edge 1, so resp_valid is
// expected to be seen high right after edge WAIT_CYCLES+2.
module tb_dmem_responder;

    localparam int WAIT_CYCLES = 2;
    localparam int EXP_LAT     = WAIT_CYCLES + 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    dmem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(WAIT_CYCLES),
        .ADDR_W     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_funct3(req_funct3),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; returns the response and the edge count to resp_valid.
    // With rr=1 the response handshake is completed before returning.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input logic rr,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        resp_ready = rr;
        @(posedge clk);
        lat = 1;
        #1;
        req_valid = 1'b0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        $display("xact we=%0b addr=%h f3=%b wdata=%h -> rdata=%h err=%0b lat=%0d",
                 we, addr, f3, wd, rd, er, lat);
        if (rr) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);

        xact(1'b0, 32'h0, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("lw0_rdata", rd, 32'h0);
        check("lw0_err", {31'd0, er}, 32'd0);
        check("lw0_lat", lat, EXP_LAT);
        check("idle_after_resp", {31'd0, req_ready}, 32'd1);

        // Word store then load.
        xact(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 1'b1, rd, er, lat);
        check("sw10_lat", lat, EXP_LAT);
        check("sw10_rdata", rd, 32'h0);
        check("sw10_err", {31'd0, er}, 32'd0);
        xact(1'b0, 32'h10, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("lw10_rdata", rd, 32'hDEADBEEF);
        check("lw10_lat", lat, EXP_LAT);

        // Sub-word stores and loads.
        xact(1'b1, 32'h20, 3'b010, 32'h11223344, 1'b1, rd, er, lat);
        xact(1'b1, 32'h21, 3'b000, 32'h00000080, 1'b1, rd, er, lat);
        xact(1'b1, 32'h22, 3'b001, 32'h0000ABCD, 1'b1, rd, er, lat);
        xact(1'b0, 32'h20, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("lw20", rd, 32'hABCD8044);
        xact(1'b0, 32'h21, 3'b000, 32'h0, 1'b1, rd, er, lat);
        check("lb21", rd, 32'hFFFFFF80);
        xact(1'b0, 32'h21, 3'b100, 32'h0, 1'b1, rd, er, lat);
        check("lbu21", rd, 32'h00000080);
        xact(1'b0, 32'h22, 3'b001, 32'h0, 1'b1, rd, er, lat);
        check("lh22", rd, 32'hFFFFABCD);
        xact(1'b0, 32'h22, 3'b101, 32'h0, 1'b1, rd, er, lat);
        check("lhu22", rd, 32'h0000ABCD);
        xact(1'b0, 32'h20, 3'b000, 32'h0, 1'b1, rd, er, lat);
        check("lb20", rd, 32'h00000044);

        // Backpressure: response held for five cycles, then released.
        xact(1'b0, 32'h20, 3'b010, 32'h0, 1'b0, rd, er, lat);
        check("bp_first_rdata", rd, 32'hABCD8044);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'hABCD8044);
            check("bp_err", {31'd0, resp_err}, 32'd0);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_release_ready", {31'd0, req_ready}, 32'd1);

        // Faults.
        xact(1'b0, 32'h400, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("oor_err", {31'd0, er}, 32'd1);
        check("oor_rdata", rd, 32'h0);
        check("oor_lat", lat, EXP_LAT);
        xact(1'b1, 32'h20, 3'b011, 32'hFFFFFFFF, 1'b1, rd, er, lat);
        check("bad_f3_store_err", {31'd0, er}, 32'd1);
        xact(1'b0, 32'h20, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("bad_f3_no_write", rd, 32'hABCD8044);
        xact(1'b0, 32'h20, 3'b110, 32'h0, 1'b1, rd, er, lat);
        check("bad_f3_load_err", {31'd0, er}, 32'd1);
        check("bad_f3_load_rdata", rd, 32'h0);
        xact(1'b1, 32'h20, 3'b100, 32'hFFFFFFFF, 1'b1, rd, er, lat);
        check("sbu_store_err", {31'd0, er}, 32'd1);

        // Last legal word.
        xact(1'b1, 32'h3FC, 3'b010, 32'h12345678, 1'b1, rd, er, lat);
        check("sw3fc_err", {31'd0, er}, 32'd0);
        xact(1'b0, 32'h3FC, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("lw3fc", rd, 32'h12345678);

        // Misaligned half load.
        xact(1'b1, 32'h20, 3'b010, 32'hABCD0000, 1'b1, rd, er, lat);
        xact(1'b0, 32'h23, 3'b001, 32'h0, 1'b1, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
        check("lh23_err", {31'd0, er}, 32'd1);
        check("lh23_rdata", rd, 32'h0);
`else
        check("lh23_err", {31'd0, er}, 32'd0);
        check("lh23_rdata", rd, 32'hFFFFABCD);
`endif
        check("lh23_lat", lat, EXP_LAT);

        // Reset during WAIT of a store.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h30;
        req_funct3 = 3'b010;
        req_wdata  = 32'h55AA55AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("wait_busy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, req_ready}, 32'd1);
        check("async_rst_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 32'h30, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("rst_wait_no_write", rd, 32'h0);
        xact(1'b0, 32'h10, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("rst_clears_mem", rd, 32'h0);

        // Reset during ACCESS of a store, before its commit edge.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h34;
        req_funct3 = 3'b010;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (WAIT_CYCLES) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 32'h34, 3'b010, 32'h0, 1'b1, rd, er, lat);
        check("rst_access_no_write", rd, 32'h0);
        check("rst_access_lat", lat, EXP_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
